mem_arbiter: RTL

- Clocked arbiter that shares one external memory port between two requesters: the fetch stage (instruction reads) and the memory stage (data loads and stores).
- Both requesters keep the pipeline's trigger/ready handshake.
- Round-robin arbitration, one outstanding transaction at a time, watchdog timeout with error return.
- Sits between the cpu top level and the unified memory model; replaces the separate ROM and RAM paths.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu memory path.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Grant encoding: which requester owns the memory port.
  localparam logic GNT_F = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Memory direction.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (F) and the
// data stage (D). One outstanding access, watchdog timeout with error return.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              triggerInF,
  input  logic [ADDR_W-1:0] addrInF,
  output logic [DATA_W-1:0] dataOutF,
  output logic              readyOutF,
  output logic              errOutF,
  input  logic              triggerInD,
  input  logic              rwInD,
  input  logic [ADDR_W-1:0] addrInD,
  input  logic [DATA_W-1:0] dataInD,
  output logic [DATA_W-1:0] dataOutD,
  output logic              readyOutD,
  output logic              errOutD,
  output logic              triggerOutM,
  output logic              rwOutM,
  output logic [ADDR_W-1:0] addrOutM,
  output logic [DATA_W-1:0] dataOutM,
  input  logic [DATA_W-1:0] dataInM,
  input  logic              readyInM
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t            state_q;
  logic              last_q;
  logic              gnt_q;
  logic              gnt_d;
  logic [CW-1:0]     cnt_q;

  logic              trigM_q;
  logic              rwM_q;
  logic [ADDR_W-1:0] addrM_q;
  logic [DATA_W-1:0] dataM_q;
  logic [DATA_W-1:0] dataF_q;
  logic [DATA_W-1:0] dataD_q;
  logic              rdyF_q;
  logic              rdyD_q;
  logic              errF_q;
  logic              errD_q;

  // Pick the winner among the active triggers; a tie goes to the port
  // that was not granted last.
  always_comb begin
    gnt_d = GNT_F;
    if (triggerInF && triggerInD) begin
      gnt_d = ~last_q;
    end else if (triggerInD) begin
      gnt_d = GNT_D;
    end
  end

  // Arbitration FSM with registered outputs and inline watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= GNT_F;
      gnt_q   <= GNT_F;
      cnt_q   <= '0;
      trigM_q <= 1'b0;
      rwM_q   <= RW_READ;
      addrM_q <= '0;
      dataM_q <= '0;
      dataF_q <= '0;
      dataD_q <= '0;
      rdyF_q  <= 1'b0;
      rdyD_q  <= 1'b0;
      errF_q  <= 1'b0;
      errD_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (triggerInF || triggerInD) begin
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            cnt_q   <= '0;
            trigM_q <= 1'b1;
            if (gnt_d == GNT_D) begin
              rwM_q   <= rwInD;
              addrM_q <= addrInD;
              dataM_q <= dataInD;
            end else begin
              rwM_q   <= RW_READ;
              addrM_q <= addrInF;
              dataM_q <= '0;
            end
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          // readyInM is checked first so it beats a coincident timeout.
          if (readyInM) begin
            trigM_q <= 1'b0;
            if (gnt_q == GNT_D) begin
              dataD_q <= dataInM;
              rdyD_q  <= 1'b1;
              errD_q  <= 1'b0;
            end else begin
              dataF_q <= dataInM;
              rdyF_q  <= 1'b1;
              errF_q  <= 1'b0;
            end
            state_q <= RESP;
          end else if (WD_EN && (cnt_q == CNT_LAST)) begin
            trigM_q <= 1'b0;
            if (gnt_q == GNT_D) begin
              dataD_q <= '0;
              rdyD_q  <= 1'b1;
              errD_q  <= 1'b1;
            end else begin
              dataF_q <= '0;
              rdyF_q  <= 1'b1;
              errF_q  <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          rdyF_q  <= 1'b0;
          rdyD_q  <= 1'b0;
          errF_q  <= 1'b0;
          errD_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign triggerOutM = trigM_q;
  assign rwOutM      = rwM_q;
  assign addrOutM    = addrM_q;
  assign dataOutM    = dataM_q;
  assign dataOutF    = dataF_q;
  assign readyOutF   = rdyF_q;
  assign errOutF     = errF_q;
  assign dataOutD    = dataD_q;
  assign readyOutD   = rdyD_q;
  assign errOutD     = errD_q;

endmodule
